// File: rtl/redmule_ctx_if.sv
// ============================================================================
// Module  : redmule_ctx_if
// Brief   : Cfg slave bus plus job valid/ready/done handshake of the context
//           register file.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface redmule_ctx_if #(
  parameter int NUM_REGS = 19,
  parameter int DW       = 32,
  parameter int ID_W     = 8
);
  logic                    cfg_req;
  logic                    cfg_gnt;
  logic                    cfg_we;
  logic [7:0]              cfg_addr;
  logic [3:0]              cfg_be;
  logic [DW-1:0]           cfg_wdata;
  logic [DW-1:0]           cfg_rdata;
  logic                    cfg_rvalid;
  logic                    job_valid;
  logic                    job_ready;
  logic [NUM_REGS*32-1:0]  job_regs;
  logic [ID_W-1:0]         job_id;
  logic                    job_done;

  modport master (
    output cfg_req, cfg_we, cfg_addr, cfg_be, cfg_wdata, job_ready, job_done,
    input  cfg_gnt, cfg_rdata, cfg_rvalid, job_valid, job_regs, job_id
  );

  modport slave (
    input  cfg_req, cfg_we, cfg_addr, cfg_be, cfg_wdata, job_ready, job_done,
    output cfg_gnt, cfg_rdata, cfg_rvalid, job_valid, job_regs, job_id
  );
endinterface

`default_nettype wire

// File: rtl/redmule_ctx_regfile.sv
// ============================================================================
// Module  : redmule_ctx_regfile
// Brief   : N_CONTEXT-slot job register file with circular job queue.
//           Optional macro REDMULE_CTX_SCRUB_EN zeroes a context when freed.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module redmule_ctx_regfile #(
  parameter int N_CONTEXT = 2,
  parameter int NUM_REGS  = 19,
  parameter int DW        = 32,
  parameter int ID_W      = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  redmule_ctx_if.slave bus,
  output logic         evt_o,
  output logic         busy_o
);

  localparam int PTR_W = $clog2(N_CONTEXT);
  localparam int CNT_W = $clog2(N_CONTEXT + 1);
  localparam logic [CNT_W-1:0] c_n_ctx    = CNT_W'(N_CONTEXT);
  localparam logic [5:0]       c_num_regs = 6'(NUM_REGS);
  localparam logic [5:0]       c_w_acq    = 6'h20;
  localparam logic [5:0]       c_w_trig   = 6'h21;
  localparam logic [5:0]       c_w_stat   = 6'h22;
  localparam logic [5:0]       c_w_clr    = 6'h23;

  logic [31:0]      r_ctx     [N_CONTEXT][NUM_REGS];
  logic [ID_W-1:0]  r_slot_id [N_CONTEXT];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [ID_W-1:0]  r_next_id;
  logic             r_acquired;
  logic             r_running;
  logic             r_evt;
  logic [DW-1:0]    r_rdata;
  logic             r_rvalid;

  logic [5:0]       w_word;
  logic [4:0]       w_reg_idx;
  logic             w_is_reg;
  logic             w_rd;
  logic             w_wr;
  logic             w_acq_grant;
  logic             w_trig;
  logic             w_clr;
  logic             w_reg_wr;
  logic             w_job_valid;
  logic             w_accept;
  logic             w_done;
  logic [DW-1:0]    w_status;
  logic [DW-1:0]    w_rdata;
  logic [1:0]       w_unused_addr;

  assign w_unused_addr = bus.cfg_addr[1:0];
  assign w_word        = bus.cfg_addr[7:2];
  assign w_reg_idx     = bus.cfg_addr[6:2];
  assign w_is_reg      = ~bus.cfg_addr[7] & ({1'b0, w_reg_idx} < c_num_regs);
  assign w_rd          = bus.cfg_req & ~bus.cfg_we;
  assign w_wr          = bus.cfg_req & bus.cfg_we;

  // Acquisition and trigger both look at the pre-update count/flags.
  assign w_acq_grant = w_rd & (w_word == c_w_acq) & ~r_acquired & (r_count < c_n_ctx);
  assign w_trig      = w_wr & (w_word == c_w_trig) & r_acquired;
  assign w_clr       = w_wr & (w_word == c_w_clr);
  assign w_reg_wr    = w_wr & w_is_reg & r_acquired;
  assign w_job_valid = (r_count != '0) & ~r_running;
  assign w_accept    = w_job_valid & bus.job_ready;
  assign w_done      = bus.job_done & r_running;

  always_comb begin
    w_status        = '0;
    w_status[7:0]   = 8'(r_count);
    w_status[15:8]  = r_running ? 8'(r_slot_id[r_rptr]) : 8'h00;
    w_status[16]    = r_running;
    w_status[17]    = r_acquired;
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_word)
        c_w_acq: begin
          if (r_acquired || (r_count < c_n_ctx)) w_rdata = DW'(r_next_id);
          else                                   w_rdata = '1;
        end
        c_w_stat: w_rdata = w_status;
        default:  if (w_is_reg) w_rdata = r_ctx[r_wptr][w_reg_idx];
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < N_CONTEXT; c++) begin
        r_slot_id[c] <= '0;
        for (int k = 0; k < NUM_REGS; k++) r_ctx[c][k] <= '0;
      end
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_next_id  <= '0;
      r_acquired <= 1'b0;
      r_running  <= 1'b0;
      r_evt      <= 1'b0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_rvalid <= bus.cfg_req;
      r_rdata  <= w_rdata;
      r_evt    <= 1'b0;
      if (w_clr) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_next_id  <= '0;
        r_acquired <= 1'b0;
        r_running  <= 1'b0;
      end else begin
        if (w_acq_grant) r_acquired <= 1'b1;
        if (w_accept)    r_running  <= 1'b1;
        if (w_done) begin
          r_running <= 1'b0;
          r_rptr    <= r_rptr + PTR_W'(1);
          r_evt     <= 1'b1;
`ifdef REDMULE_CTX_SCRUB_EN
          for (int k = 0; k < NUM_REGS; k++) r_ctx[r_rptr][k] <= '0;
`endif
        end
        // The freed slot never equals the staging slot while acquired.
        if (w_reg_wr) begin
          for (int b = 0; b < 4; b++)
            if (bus.cfg_be[b])
              r_ctx[r_wptr][w_reg_idx][8*b +: 8] <= bus.cfg_wdata[8*b +: 8];
        end
        if (w_trig) begin
          r_slot_id[r_wptr] <= r_next_id;
          r_wptr            <= r_wptr + PTR_W'(1);
          r_next_id         <= r_next_id + ID_W'(1);
          r_acquired        <= 1'b0;
        end
        case ({w_trig, w_done})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_job_regs
    assign bus.job_regs[32*k +: 32] = r_ctx[r_rptr][k];
  end

  assign bus.cfg_gnt    = bus.cfg_req;
  assign bus.cfg_rdata  = r_rdata;
  assign bus.cfg_rvalid = r_rvalid;
  assign bus.job_valid  = w_job_valid;
  assign bus.job_id     = r_slot_id[r_rptr];
  assign evt_o          = r_evt;
  assign busy_o         = r_running | (r_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_redmule_ctx_regfile.sv
// ============================================================================
// Module  : tb_redmule_ctx_regfile
// Brief   : Directed plus random bench against a queue-based job model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_redmule_ctx_regfile;
  localparam int N_CONTEXT = 2;
  localparam int NUM_REGS  = 19;
  localparam int ID_W      = 8;
`ifdef REDMULE_CTX_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic evt;
  logic busy;

  redmule_ctx_if #(.NUM_REGS(NUM_REGS), .DW(32), .ID_W(ID_W)) bus ();

  redmule_ctx_regfile #(
    .N_CONTEXT(N_CONTEXT), .NUM_REGS(NUM_REGS), .DW(32), .ID_W(ID_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave),
    .evt_o (evt),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int slot; int id;} job_t;

  logic [31:0] m_mem [N_CONTEXT][NUM_REGS];
  job_t        m_q[$];
  int          m_commits;
  int          m_next_id;
  bit          m_acq;
  bit          m_run;
  bit          m_evt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CONTEXT; c++)
      for (int k = 0; k < NUM_REGS; k++) m_mem[c][k] = '0;
    m_q.delete();
    m_commits = 0;
    m_next_id = 0;
    m_acq = 0;
    m_run = 0;
    m_evt = 0;
  endtask

  // One clock cycle of stimulus, model update and output comparison.
  task automatic cycle(input bit req, input bit we, input logic [7:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       input bit ready, input bit done, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic [7:0]  a;
    int          wslot, idx, k;
    bit          clr, acc, fin, trig, wr, acq_set;
    job_t        popped;
    bus.cfg_req   = req;
    bus.cfg_we    = we;
    bus.cfg_addr  = addr;
    bus.cfg_be    = be;
    bus.cfg_wdata = wd;
    bus.job_ready = ready;
    bus.job_done  = done;

    a       = {addr[7:2], 2'b00};
    wslot   = m_commits % N_CONTEXT;
    idx     = int'(addr[6:2]);
    exp_rd  = '0;
    acq_set = 0;
    if (req && !we) begin
      if (a == 8'h80) begin
        if (m_acq) exp_rd = 32'(m_next_id);
        else if (m_q.size() < N_CONTEXT) begin
          exp_rd  = 32'(m_next_id);
          acq_set = 1;
        end else exp_rd = 32'hFFFF_FFFF;
      end else if (a == 8'h88) begin
        exp_rd = {14'b0, m_acq, m_run,
                  (m_run ? 8'(m_q[0].id) : 8'h00), 8'(m_q.size())};
      end else if (int'(a) < 4 * NUM_REGS) begin
        exp_rd = m_mem[wslot][idx];
      end
    end
    clr  = req && we && a == 8'h8C;
    trig = req && we && a == 8'h84 && m_acq;
    wr   = req && we && int'(a) < 4 * NUM_REGS && m_acq;
    acc  = m_q.size() > 0 && !m_run && ready;
    fin  = m_run && done;

    m_evt = 0;
    if (clr) begin
      m_q.delete();
      m_commits = 0;
      m_next_id = 0;
      m_acq = 0;
      m_run = 0;
    end else begin
      if (acq_set) m_acq = 1;
      if (wr)
        for (int b = 0; b < 4; b++)
          if (be[b]) m_mem[wslot][idx][8*b +: 8] = wd[8*b +: 8];
      if (fin) begin
        popped = m_q.pop_front();
        m_run  = 0;
        m_evt  = 1;
        if (SCRUB)
          for (int r = 0; r < NUM_REGS; r++) m_mem[popped.slot][r] = '0;
      end
      if (trig) begin
        m_q.push_back('{slot: wslot, id: m_next_id});
        m_commits++;
        m_next_id = (m_next_id + 1) % (1 << ID_W);
        m_acq = 0;
      end
      if (acc) m_run = 1;
    end

    @(posedge clk);
    #1;
    rd = bus.cfg_rdata;
    check("rvalid", 32'(bus.cfg_rvalid), 32'(req));
    check("gnt", 32'(bus.cfg_gnt), 32'(req));
    if (req && !we) check("rdata", bus.cfg_rdata, exp_rd);
    check("evt", 32'(evt), 32'(m_evt));
    check("job_valid", 32'(bus.job_valid), 32'(m_q.size() > 0 && !m_run));
    check("busy", 32'(busy), 32'(m_run || m_q.size() > 0));
    if (m_q.size() > 0) begin
      k = $urandom_range(0, NUM_REGS - 1);
      check("job_id", 32'(bus.job_id), 32'(m_q[0].id));
      check("job_reg0", bus.job_regs[31:0], m_mem[m_q[0].slot][0]);
      check("job_regk", bus.job_regs[32*k +: 32], m_mem[m_q[0].slot][k]);
    end
    bus.cfg_req   = 1'b0;
    bus.job_done  = 1'b0;
    bus.job_ready = 1'b0;
  endtask

  task automatic rd_op(input logic [7:0] addr, output logic [31:0] rd);
    cycle(1, 0, addr, 4'h0, 32'h0, 0, 0, rd);
  endtask

  task automatic wr_op(input logic [7:0] addr, input logic [31:0] wd);
    logic [31:0] unused_rd;
    cycle(1, 1, addr, 4'hF, wd, 0, 0, unused_rd);
  endtask

  task automatic idle(input bit ready, input bit done);
    logic [31:0] unused_rd;
    cycle(0, 0, 8'h0, 4'h0, 32'h0, ready, done, unused_rd);
  endtask

  logic [31:0] rd;
  logic [7:0]  addr;
  int          op;

  initial begin
    rst = 1'b1;
    bus.cfg_req = 0; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_be = 0;
    bus.cfg_wdata = 0; bus.job_ready = 0; bus.job_done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", 32'(bus.cfg_rvalid), 32'h0);
    check("rst_job_id", 32'(bus.job_id), 32'h0);
    rst = 1'b0;
    check("rst_job_valid", 32'(bus.job_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rd_op(8'h88, rd);
    check("status_after_reset", rd, 32'h0);

    // First job: acquire, program, trigger.
    rd_op(8'h80, rd);
    check("acquire_first", rd, 32'h0);
    wr_op(8'h00, 32'h0000_1000);
    wr_op(8'h48, 32'h0000_ABCD);
    wr_op(8'h84, 32'h0);
    check("trig_valid", 32'(bus.job_valid), 32'h1);
    check("trig_reg0", bus.job_regs[31:0], 32'h0000_1000);
    check("trig_reg18", bus.job_regs[18*32 +: 32], 32'h0000_ABCD);
    check("trig_id", 32'(bus.job_id), 32'h0);

    // Fill the queue, then a further acquire is refused.
    rd_op(8'h80, rd);
    check("acquire_second", rd, 32'h1);
    wr_op(8'h84, 32'h0);
    rd_op(8'h80, rd);
    check("acquire_full", rd, 32'hFFFF_FFFF);
    rd_op(8'h88, rd);
    check("status_count2", {24'h0, rd[7:0]}, 32'h2);

    // Run and complete job 0.
    idle(1, 0);
    check("running_status_busy", 32'(busy), 32'h1);
    idle(0, 1);
    check("evt_after_done", 32'(evt), 32'h1);
    check("head_id_after_done", 32'(bus.job_id), 32'h1);
    rd_op(8'h88, rd);
    check("evt_one_cycle", 32'(evt), 32'h0);
    check("status_count1", {24'h0, rd[7:0]}, 32'h1);

    // Slot 0 re-acquired: scrubbed or holding old contents.
    rd_op(8'h80, rd);
    check("acquire_third", rd, 32'h2);
    rd_op(8'h00, rd);
    check("reacquire_reg0", rd, SCRUB ? 32'h0 : 32'h0000_1000);

    // Trigger and done in the same cycle keep the count.
    idle(1, 0);
    cycle(1, 1, 8'h84, 4'hF, 32'h0, 0, 1, rd);
    check("trig_done_id", 32'(bus.job_id), 32'h2);
    rd_op(8'h88, rd);
    check("trig_done_count", {24'h0, rd[7:0]}, 32'h1);

    // Soft clear drops the queue.
    wr_op(8'h8C, 32'h0);
    rd_op(8'h88, rd);
    check("clear_status", rd, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1: cycle(1, 0, 8'h80, 4'h0, 32'h0, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0, rd);
        2, 3: begin
          addr = 8'($urandom_range(0, NUM_REGS - 1) * 4);
          cycle(1, 1, addr, 4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, rd);
        end
        4: begin
          addr = 8'($urandom_range(0, 31) * 4);
          cycle(1, 0, addr, 4'h0, 32'h0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, rd);
        end
        5, 6: cycle(1, 1, 8'h84, 4'hF, $urandom, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, rd);
        7: cycle(1, 0, 8'h88, 4'h0, 32'h0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, rd);
        8: begin
          addr = 8'($urandom_range(32, 63) * 4);
          if (addr == 8'h8C) addr = 8'h88;
          cycle(1, $urandom_range(0, 1) == 1, addr, 4'hF, $urandom,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, rd);
        end
        default: begin
          if ($urandom_range(0, 19) == 0) wr_op(8'h8C, 32'h0);
          else idle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end
      endcase
    end

    // Reset in the middle of a job drops everything without an event.
    rd_op(8'h80, rd);
    wr_op(8'h84, 32'h0);
    idle(1, 0);
    bus.job_done = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.job_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_evt", 32'(evt), 32'h0);
    check("midrst_regs", bus.job_regs[31:0], 32'h0);
    @(posedge clk);
    #1;
    bus.job_done = 1'b0;
    check("midrst_evt_hold", 32'(evt), 32'h0);
    rst = 1'b0;
    model_reset();
    rd_op(8'h88, rd);
    check("status_after_midrst", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
